otter_fetch_stage: RTL and testbench

//  Instruction-fetch (IF) stage of the pipelined OTTER RV32I core; directly upstream of decode.

---
 rtl/otter_fetch_stage.sv | 155 +++++++++++++++
 tb/tb_otter_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_fetch_stage.sv
// OTTER RV32I instruction-fetch stage: owns the fetch PC, issues in-order imem requests,
// buffers responses and drives the IF/DE pipeline register with stall and redirect handling.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_de,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_de_valid,
  output logic [31:0] if_de_pc,
  output logic [31:0] if_de_ir
);

  localparam int              CW       = $clog2(BUF_DEPTH + 1);
  localparam int              PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0]     DEPTH_C  = (CW + 1)'(BUF_DEPTH);
  localparam logic [CW-1:0]   FULL_C   = CW'(BUF_DEPTH);
  localparam logic [PW-1:0]   PTR_LAST = PW'(BUF_DEPTH - 1);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;

  logic [31:0]   r_pcq [BUF_DEPTH];
  logic [PW-1:0] r_pcq_wr;
  logic [PW-1:0] r_pcq_rd;

  logic [31:0]   r_fq_pc [BUF_DEPTH];
  logic [31:0]   r_fq_ir [BUF_DEPTH];
  logic [PW-1:0] r_fq_wr;
  logic [PW-1:0] r_fq_rd;
  logic [CW-1:0] r_fq_cnt;

  logic          r_vld_p1;
  logic [31:0]   r_pc_p1;
  logic [31:0]   r_ir_p1;

  logic          w_credit;
  logic          w_hs;
  logic          w_rsp;
  logic          w_drop;
  logic          w_keep;
  logic [CW-1:0] w_out_nxt;
  logic          w_fq_empty;
  logic          w_fq_push;
  logic          w_fq_pop;
  logic [31:0]   w_keep_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Outstanding requests plus buffered responses never exceed the FIFO depth,
  // so every response that is kept always has a free FIFO slot.
  assign w_credit  = ({1'b0, r_out} + {1'b0, r_fq_cnt}) < DEPTH_C;
  assign imem_req  = rst_n & ~redirect & w_credit;
  assign imem_addr = r_fetch_pc;
  assign w_hs      = imem_req & imem_gnt;

  // A response with nothing outstanding (e.g. a straggler from before reset) is ignored.
  assign w_rsp      = imem_rvalid & (r_out != '0);
  assign w_drop     = w_rsp & (r_drop != '0);
  assign w_keep     = w_rsp & (r_drop == '0);
  assign w_out_nxt  = r_out + CW'(w_hs) - CW'(w_rsp);
  assign w_keep_pc  = r_pcq[r_pcq_rd];

  assign w_fq_empty = (r_fq_cnt == '0);
  assign w_fq_pop   = ~redirect & ~stall_de & ~w_fq_empty;
  assign w_fq_push  = ~redirect & w_keep & (stall_de | ~w_fq_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_VEC;
      r_out      <= '0;
      r_drop     <= '0;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      r_fq_wr    <= '0;
      r_fq_rd    <= '0;
      r_fq_cnt   <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        r_drop     <= w_out_nxt;
        r_pcq_wr   <= '0;
        r_pcq_rd   <= '0;
        r_fq_wr    <= '0;
        r_fq_rd    <= '0;
        r_fq_cnt   <= '0;
      end else begin
        if (w_hs) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_pcq_wr   <= ptr_inc(r_pcq_wr);
        end
        if (w_drop)    r_drop   <= r_drop - CW'(1);
        if (w_keep)    r_pcq_rd <= ptr_inc(r_pcq_rd);
        if (w_fq_push) r_fq_wr  <= ptr_inc(r_fq_wr);
        if (w_fq_pop)  r_fq_rd  <= ptr_inc(r_fq_rd);
        r_fq_cnt <= r_fq_cnt + CW'(w_fq_push) - CW'(w_fq_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) r_pcq[r_pcq_wr] <= r_fetch_pc;
    if (w_fq_push) begin
      r_fq_pc[r_fq_wr] <= w_keep_pc;
      r_fq_ir[r_fq_wr] <= imem_rdata;
    end
  end

  // IF/DE boundary: FIFO head first, then same-cycle bypass, otherwise a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_pc_p1  <= 32'h0;
      r_ir_p1  <= NOP_INSTR;
    end else if (redirect) begin
      r_vld_p1 <= 1'b0;
      r_ir_p1  <= NOP_INSTR;
    end else if (!stall_de) begin
      if (!w_fq_empty) begin
        r_vld_p1 <= 1'b1;
        r_pc_p1  <= r_fq_pc[r_fq_rd];
        r_ir_p1  <= r_fq_ir[r_fq_rd];
      end else if (w_keep) begin
        r_vld_p1 <= 1'b1;
        r_pc_p1  <= w_keep_pc;
        r_ir_p1  <= imem_rdata;
      end else begin
        r_vld_p1 <= 1'b0;
        r_ir_p1  <= NOP_INSTR;
      end
    end
  end

  assign if_de_valid = r_vld_p1;
  assign if_de_pc    = r_pc_p1;
  assign if_de_ir    = r_ir_p1;

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_keep && (r_fq_cnt == FULL_C)));

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: random memory/stall/redirect stimulus checked every cycle
// against a program-order reference model, plus directed scenarios with literal expectations.
module tb_otter_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall_de = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_de_valid;
  logic [31:0] if_de_pc;
  logic [31:0] if_de_ir;

  otter_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_de(stall_de), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_de_valid(if_de_valid), .if_de_pc(if_de_pc), .if_de_ir(if_de_ir)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ready; bit stale; } fl_t;

  fl_t         inflight[$];
  logic [31:0] bufq[$];
  logic [31:0] m_pc;
  logic        e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_ir;
  bit          e_req;
  int          cyc = 0;
  int          lat = 1;
  bit          spurious = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h3C5A_0F96;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    bufq.delete();
    m_pc    = 32'h0;
    e_valid = 1'b0;
    e_pc    = 32'h0;
    e_ir    = NOP;
  endtask

  task automatic compare();
    e_req = rst_n && !redirect && ((inflight.size() + bufq.size()) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    chk("if_de_valid", 32'(if_de_valid), 32'(e_valid));
    chk("if_de_pc", if_de_pc, e_pc);
    chk("if_de_ir", if_de_ir, e_ir);
  endtask

  // Program-order view: requests go out pc, pc+4, ...; kept responses line up behind
  // whatever decode has not yet taken; a redirect discards the whole old path.
  task automatic update();
    bit          keep = 0;
    logic [31:0] apc = 32'h0;
    bit          hs;
    hs = e_req && imem_gnt;
    if (imem_rvalid && inflight.size() > 0) begin
      keep = !inflight[0].stale;
      apc  = inflight[0].addr;
      void'(inflight.pop_front());
    end
    if (redirect) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      bufq.delete();
      e_valid = 1'b0;
      e_ir    = NOP;
      m_pc    = {redirect_pc[31:2], 2'b00};
    end else begin
      if (keep) bufq.push_back(apc);
      if (!stall_de) begin
        if (bufq.size() > 0) begin
          e_pc    = bufq.pop_front();
          e_valid = 1'b1;
          e_ir    = mem(e_pc);
        end else begin
          e_valid = 1'b0;
          e_ir    = NOP;
        end
      end
    end
    if (hs) begin
      inflight.push_back('{addr: m_pc, ready: cyc + lat, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic begin_cycle(input bit g, input bit st, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    imem_gnt    = g;
    stall_de    = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (inflight.size() > 0 && cyc >= inflight[0].ready) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem(inflight[0].addr);
    end else if (spurious && inflight.size() == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    compare();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    if (rst_n) update();
    cyc++;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt = 1'b0;
    redirect = 1'b0;
    stall_de = 1'b0;
    model_reset();
    #1;
    chk("rst_imm_valid", 32'(if_de_valid), 32'h0);
    chk("rst_imm_pc", if_de_pc, 32'h0);
    chk("rst_imm_ir", if_de_ir, 32'h0000_0013);
    chk("rst_imm_req", 32'(imem_req), 32'h0);
    repeat (2) begin
      @(negedge clk);
      #1;
      compare();
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    logic [31:0] rtgt;

    model_reset();
    repeat (2) begin
      @(negedge clk);
      #1;
      compare();
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Streaming with a one-cycle memory, then a 3-cycle decode stall.
    lat = 1;
    for (int k = 0; k < 23; k++) begin
      begin_cycle(1'b1, (k >= 12 && k <= 14), 1'b0, 32'h0);
      if (k == 0)  chk("first_addr", imem_addr, 32'h0);
      if (k == 0)  chk("first_req", 32'(imem_req), 32'h1);
      if (k == 2)  chk("first_valid", 32'(if_de_valid), 32'h1);
      if (k == 2)  chk("first_pc", if_de_pc, 32'h0);
      if (k == 2)  chk("first_ir", if_de_ir, mem(32'h0));
      if (k == 3)  chk("second_pc", if_de_pc, 32'h4);
      if (k == 7)  chk("stream_pc", if_de_pc, 32'h14);
      if (k == 7)  chk("stream_addr", imem_addr, 32'h1C);
      if (k == 14) chk("stall_req_off", 32'(imem_req), 32'h0);
      if (k == 15) chk("stall_hold_pc", if_de_pc, 32'h28);
      if (k == 16) chk("stall_next_pc", if_de_pc, 32'h2C);
      if (k == 18) chk("stall_bypass_pc", if_de_pc, 32'h34);
      end_cycle();
    end

    // Slow memory fills both credits, then a redirect must drop the late responses.
    lat = 3;
    repeat (6) begin begin_cycle(1'b1, 1'b0, 1'b0, 32'h0); end_cycle(); end
    begin_cycle(1'b1, 1'b0, 1'b1, 32'h0000_01EC);
    chk("redir_req_off", 32'(imem_req), 32'h0);
    end_cycle();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      if (i == 0) chk("redir_addr", imem_addr, 32'h1EC);
      if (if_de_valid) begin
        found = 1;
        chk("redir_first_pc", if_de_pc, 32'h1EC);
        chk("redir_first_ir", if_de_ir, mem(32'h1EC));
      end
      end_cycle();
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL redir_timeout: got no valid after 20 cycles, required pc 000001ec");
    end

    // Redirect together with a stall, then the grant withheld for 4 cycles.
    lat = 1;
    repeat (8) begin begin_cycle(1'b1, 1'b0, 1'b0, 32'h0); end_cycle(); end
    begin_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0402);
    end_cycle();
    for (int k = 0; k < 7; k++) begin
      begin_cycle((k < 3), 1'b0, 1'b0, 32'h0);
      if (k == 0) chk("rs_valid", 32'(if_de_valid), 32'h0);
      if (k == 0) chk("rs_addr", imem_addr, 32'h400);
      if (k >= 3) chk("gnt_wait_addr", imem_addr, 32'h40C);
      if (k >= 3) chk("gnt_wait_req", 32'(imem_req), 32'h1);
      if (k == 6) chk("drain_valid", 32'(if_de_valid), 32'h0);
      if (k == 6) chk("drain_ir", if_de_ir, 32'h0000_0013);
      end_cycle();
    end

    // Asynchronous reset mid-burst, a straggler response, then a wrapping redirect.
    repeat (3) begin begin_cycle(1'b1, 1'b0, 1'b0, 32'h0); end_cycle(); end
    async_reset();
    spurious = 1;
    begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_restart_addr", imem_addr, 32'h0);
    end_cycle();
    spurious = 0;
    repeat (4) begin begin_cycle(1'b1, 1'b0, 1'b0, 32'h0); end_cycle(); end
    begin_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    end_cycle();
    begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    end_cycle();
    begin_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr1", imem_addr, 32'h0);
    end_cycle();

    // Random mix of grant waits, latencies, stalls and redirects.
    for (int k = 0; k < 3000; k++) begin
      lat  = $urandom_range(1, 3);
      rtgt = $urandom;
      begin_cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 39) == 0), rtgt);
      end_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
